alramfifo_pf: RTL and testbench

Single-clock FIFO that wraps the team's two-cycle-latency dual-port RAM (`alsyncram112x`) and drives its read side. It issues RAM reads ahead of demand into a small output queue, so downstream sees a show-ahead valid/ready stream at one word per clock despite the registered RAM output. It sits between any producer writing bursts into block or distributed RAM and a consumer that applies backpressure.

---
 rtl/alramfifo_pf_pkg.sv | 8 +
 rtl/alramfifo_pf_if.sv | 24 ++
 rtl/alsyncram112x.sv | 41 ++++
 rtl/alramfifo_pf.sv | 119 +++++++++++
 tb/tb_alramfifo_pf.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alramfifo_pf_pkg.sv
// Shared constants for the prefetching RAM FIFO: RAM read latency and the
// output-queue depth that hides it.
package alramfifo_pf_pkg;

    localparam int unsigned AL_RAM_RDLAT  = 2;
    localparam int unsigned AL_PF_OQDEPTH = AL_RAM_RDLAT + 1;

endpackage

// File: rtl/alramfifo_pf_if.sv
// Write strobe/data plus show-ahead read stream of alramfifo_pf.
interface alramfifo_pf_if #(
    parameter int unsigned ADDRBIT = 6,
    parameter int unsigned WIDTH   = 8
);
    logic               wr_en;
    logic [WIDTH-1:0]   wr_data;
    logic               full;
    logic               ovf;
    logic               rd_valid;
    logic               rd_ready;
    logic [WIDTH-1:0]   rd_data;
    logic [ADDRBIT+1:0] level;

    modport master (
        output wr_en, wr_data, rd_ready,
        input  full, ovf, rd_valid, rd_data, level
    );

    modport slave (
        input  wr_en, wr_data, rd_ready,
        output full, ovf, rd_valid, rd_data, level
    );
endinterface

// File: rtl/alsyncram112x.sv
// Simple dual-port RAM with registered read address and registered output:
// rdaddress sampled at edge n gives q valid after edge n+1.
module alsyncram112x #(
    parameter int unsigned ADDRBIT = 6,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned WIDTH   = 8,
    parameter string       TYPE    = "AUTO"
) (
    input  logic               wrclock,
    input  logic               wren,
    input  logic [ADDRBIT-1:0] wraddress,
    input  logic [WIDTH-1:0]   data,
    input  logic               rdclock,
    input  logic [ADDRBIT-1:0] rdaddress,
    output logic [WIDTH-1:0]   q
);

    logic [ADDRBIT-1:0] rd_addr_q;
    logic [WIDTH-1:0]   rd_word;

    // TYPE only steers the memory implementation hint; behaviour is identical.
    if (TYPE == "DISTRIBUTED") begin : g_dist
        (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge wrclock) begin
            if (wren) mem[wraddress] <= data;
        end
        assign rd_word = mem[rd_addr_q];
    end else begin : g_blk
        (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge wrclock) begin
            if (wren) mem[wraddress] <= data;
        end
        assign rd_word = mem[rd_addr_q];
    end

    always_ff @(posedge rdclock) begin
        rd_addr_q <= rdaddress;
        q         <= rd_word;
    end

endmodule

// File: rtl/alramfifo_pf.sv
// Single-clock FIFO over alsyncram112x that prefetches into a small output
// queue so the consumer sees a show-ahead stream at one word per clock.
module alramfifo_pf
    import alramfifo_pf_pkg::*;
#(
    parameter int unsigned ADDRBIT = 6,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned WIDTH   = 8,
    parameter string       TYPE    = "AUTO"
) (
    input  logic          clk,
    input  logic          rstn,
    alramfifo_pf_if.slave bus
);

    localparam int unsigned CW = ADDRBIT + 1;
    localparam int unsigned LW = ADDRBIT + 2;
    localparam int unsigned QW = $clog2(AL_PF_OQDEPTH + 1);
    localparam int unsigned HW = QW + 2;

    logic [ADDRBIT-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]           ram_cnt, ram_cnt_nxt;
    logic [AL_RAM_RDLAT-1:0] vpipe, vpipe_nxt;
    logic [QW-1:0]           oq_cnt, oq_cnt_nxt;
    logic [WIDTH-1:0]        oq     [AL_PF_OQDEPTH];
    logic [WIDTH-1:0]        oq_nxt [AL_PF_OQDEPTH];
    logic [WIDTH-1:0]        ram_q;
    logic [HW-1:0]           held;
    logic [LW-1:0]           level_q, level_nxt;
    logic                    full_q, ovf_q, rd_valid_q;
    logic                    wr_acc, pop, push, issue;

    alsyncram112x #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .TYPE    (TYPE)
    ) u_ram (
        .wrclock   (clk),
        .wren      (wr_acc),
        .wraddress (wr_ptr),
        .data      (bus.wr_data),
        .rdclock   (clk),
        .rdaddress (rd_ptr),
        .q         (ram_q)
    );

    // Credit check: words queued or in flight, minus this cycle's pop, must leave room.
    always_comb begin
        wr_acc = bus.wr_en && !full_q;
        pop    = rd_valid_q && bus.rd_ready;
        push   = vpipe[AL_RAM_RDLAT-1];
        held   = HW'(oq_cnt);
        for (int i = 0; i < int'(AL_RAM_RDLAT); i++) begin
            held = held + HW'(vpipe[i]);
        end
        issue       = (ram_cnt != '0) && (held < HW'(AL_PF_OQDEPTH) + HW'(pop));
        ram_cnt_nxt = ram_cnt + CW'(wr_acc) - CW'(issue);
        vpipe_nxt   = {vpipe[AL_RAM_RDLAT-2:0], issue};
    end

    // Output queue: pop shifts toward entry 0, push lands behind the survivors.
    always_comb begin
        oq_nxt     = oq;
        oq_cnt_nxt = oq_cnt;
        if (pop) begin
            for (int i = 0; i < int'(AL_PF_OQDEPTH) - 1; i++) begin
                oq_nxt[i] = oq[i+1];
            end
            oq_cnt_nxt = oq_cnt_nxt - QW'(1);
        end
        if (push) begin
            for (int i = 0; i < int'(AL_PF_OQDEPTH); i++) begin
                if (QW'(i) == oq_cnt_nxt) oq_nxt[i] = ram_q;
            end
            oq_cnt_nxt = oq_cnt_nxt + QW'(1);
        end
        level_nxt = LW'(ram_cnt_nxt) + LW'(oq_cnt_nxt);
        for (int i = 0; i < int'(AL_RAM_RDLAT); i++) begin
            level_nxt = level_nxt + LW'(vpipe_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            vpipe      <= '0;
            oq_cnt     <= '0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            level_q    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDRBIT'(1);
            if (issue)  rd_ptr <= rd_ptr + ADDRBIT'(1);
            ram_cnt    <= ram_cnt_nxt;
            vpipe      <= vpipe_nxt;
            oq_cnt     <= oq_cnt_nxt;
            full_q     <= (ram_cnt_nxt == CW'(DEPTH));
            ovf_q      <= bus.wr_en && full_q;
            rd_valid_q <= (oq_cnt_nxt != '0);
            level_q    <= level_nxt;
        end
    end

    // Queue payload needs no reset; validity is carried by oq_cnt.
    always_ff @(posedge clk) begin
        oq <= oq_nxt;
    end

    assign bus.full     = full_q;
    assign bus.ovf      = ovf_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = oq[0];
    assign bus.level    = level_q;

endmodule

// File: tb/tb_alramfifo_pf.sv
// Self-checking bench for alramfifo_pf: directed vector table, multi-cycle
// corner sequences and randomized traffic against a queue-based reference.
module tb_alramfifo_pf;

    localparam int ADDRBIT = 6;
    localparam int DEPTH   = 64;
    localparam int WIDTH   = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    alramfifo_pf_if #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH)) bus ();

    alramfifo_pf #(
        .ADDRBIT (ADDRBIT),
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .TYPE    ("AUTO")
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       rr;
        logic       ev;
        logic [7:0] ed;
        int         el;
    } vec_t;

    vec_t       tbl [12];
    logic [7:0] model_q [$];
    int         n_pass = 0;
    int         n_total = 0;
    logic       exp_ovf = 1'b0;
    int         gap = 0;
    int         ovf_seen = 0;
    int         cyc = 0;
    int         valid_cnt = 0;
    int         first_v = -1;
    int         last_v = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: the FIFO holds exactly the accepted-but-not-popped words, in order.
    task automatic check_model();
        chk("level", int'(bus.level), model_q.size());
        chk("ovf", int'(bus.ovf), int'(exp_ovf));
        if (bus.rd_valid) begin
            chk("valid_nonempty", int'(model_q.size() != 0), 1);
            if (model_q.size() != 0) chk("rd_data", int'(bus.rd_data), int'(model_q[0]));
        end
        if (model_q.size() != 0 && !bus.rd_valid) gap++;
        else gap = 0;
        chk("head_latency", int'(gap <= 3), 1);
        chk("full_only_when_ram_full", int'(!bus.full || model_q.size() >= DEPTH), 1);
        chk("level_max", int'(int'(bus.level) <= DEPTH + 3), 1);
    endtask

    task automatic step(input logic we, input logic [7:0] wd, input logic rr);
        logic pop, acc;
        check_model();
        if (bus.ovf) ovf_seen++;
        if (bus.rd_valid) begin
            valid_cnt++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        pop = bus.rd_valid && rr;
        acc = we && !bus.full;
        bus.wr_en    = we;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        if (pop && model_q.size() != 0) void'(model_q.pop_front());
        if (acc) model_q.push_back(wd);
        exp_ovf = we && bus.full;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && model_q.size() != 0; k++) step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", model_q.size(), 0);
        step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int c0;
        int acc_total;
        logic we, rr;

        bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;

        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1};
        tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_valid", int'(bus.rd_valid), 0);
        chk("reset_full", int'(bus.full), 0);
        chk("reset_level", int'(bus.level), 0);
        chk("reset_ovf", int'(bus.ovf), 0);
        rstn = 1'b1;

        // Directed vectors: single word, then a stalled pair
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].we, tbl[i].wd, tbl[i].rr);
            chk($sformatf("vec%0d_valid", i), int'(bus.rd_valid), int'(tbl[i].ev));
            chk($sformatf("vec%0d_level", i), int'(bus.level), tbl[i].el);
            if (tbl[i].ev) chk($sformatf("vec%0d_data", i), int'(bus.rd_data), int'(tbl[i].ed));
        end

        // Streaming 0..199 with the consumer always ready
        valid_cnt = 0; first_v = -1; last_v = -1; c0 = cyc;
        for (int i = 0; i < 200; i++) step(1'b1, 8'(i), 1'b1);
        drain();
        chk("stream_count", valid_cnt, 200);
        chk("stream_no_gaps", last_v - first_v + 1, 200);
        chk("stream_first_latency", first_v - c0, 4);

        // Fill and overflow with the consumer stalled
        ovf_seen = 0;
        for (int i = 0; i < 70; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("fill_level", int'(bus.level), DEPTH + 3);
        chk("fill_full", int'(bus.full), 1);
        chk("fill_ovf_pulses", ovf_seen, 3);
        drain();
        chk("fill_full_cleared", int'(bus.full), 0);

        // Pointer wrap with the level hovering around 10
        acc_total = 0;
        for (int k = 0; k < 3000 && acc_total < 3 * DEPTH + 8; k++) begin
            we = (model_q.size() <= 10) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rr = (model_q.size() >= 10) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if (we && !bus.full) acc_total++;
            step(we, 8'(k * 7 + 3), rr);
        end
        chk("wrap_progress", int'(acc_total >= 3 * DEPTH), 1);
        drain();

        // Random backpressure with continuous writes
        for (int k = 0; k < 600; k++) step(1'b1, 8'(k), 1'($urandom_range(0, 1)));
        drain();

        // Reset in the middle of a burst
        for (int i = 0; i < 20; i++) step(1'b1, 8'(100 + i), 1'b0);
        chk("pre_reset_level", int'(bus.level), 20);
        bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
        #2 rstn = 1'b0;
        #1;
        chk("midrst_valid", int'(bus.rd_valid), 0);
        chk("midrst_full", int'(bus.full), 0);
        chk("midrst_level", int'(bus.level), 0);
        @(negedge clk);
        bus.wr_en = 1'b0;
        rstn = 1'b1;
        model_q.delete(); exp_ovf = 1'b0; gap = 0;
        step(1'b1, 8'h3C, 1'b0);
        chk("post_rst_e0_valid", int'(bus.rd_valid), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_e1_valid", int'(bus.rd_valid), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_e2_valid", int'(bus.rd_valid), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_e3_valid", int'(bus.rd_valid), 1);
        chk("post_rst_e3_data", int'(bus.rd_data), 8'h3C);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
